ni_packet_tx: RTL and testbench

//  Credit-based packet transmitter for a router LOCAL input port.
//  - Sits in the processing element's network interface.
//  - Takes a send command (target, size) and a payload flit stream from the core.
//  - Emits one HeMPS packet into the router: header flit, size flit, then payload flits.
//  - Honours credit_i, so that no flit is lost or duplicated.

---
 rtl/ni_packet_tx_pkg.sv | 16 +
 rtl/ni_packet_tx_if.sv | 26 ++
 rtl/ni_packet_tx_fifo.sv | 52 +++++
 rtl/ni_packet_tx.sv | 143 ++++++++++++++
 tb/tb_ni_packet_tx.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ni_packet_tx_pkg.sv
// Shared NI/router definitions: flit types and the packet transmitter state encoding.
package ni_packet_tx_pkg;

  localparam int unsigned TAM_FLIT = 16;

  typedef logic [TAM_FLIT-1:0] regflit;
  typedef logic [7:0]          regmetadeflit;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    SIZE,
    PAYLOAD
  } ni_tx_state_t;

endpackage

// File: rtl/ni_packet_tx_if.sv
// Core-side command and payload handshakes of the packet transmitter.
interface ni_packet_tx_if
  import ni_packet_tx_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = TAM_FLIT
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  regmetadeflit          cmd_target;
  logic [FLIT_WIDTH-1:0] cmd_size;
  logic                  pl_valid;
  logic                  pl_ready;
  logic [FLIT_WIDTH-1:0] pl_data;

  modport master (
    output cmd_valid, cmd_target, cmd_size, pl_valid, pl_data,
    input  cmd_ready, pl_ready
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_size, pl_valid, pl_data,
    output cmd_ready, pl_ready
  );

endinterface

// File: rtl/ni_packet_tx_fifo.sv
// Payload decoupling FIFO between the core and the transmitter output slot.
module ni_flit_fifo #(
  parameter int unsigned FLIT_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FLIT_WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [FLIT_WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ni_packet_tx.sv
// Credit-based HeMPS packet transmitter: header, size, then payload flits into the router LOCAL port.
module ni_packet_tx
  import ni_packet_tx_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = TAM_FLIT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  ni_packet_tx_if.slave         core,
  output logic                  clock_tx,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_out,
  input  logic                  credit_i,
  output logic                  busy,
  output logic                  pkt_done
);

  ni_tx_state_t          state;
  ni_tx_state_t          state_nxt;
  logic [FLIT_WIDTH-1:0] size_q;
  logic [FLIT_WIDTH-1:0] remaining;
  logic [FLIT_WIDTH-1:0] accepted;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FLIT_WIDTH-1:0] fifo_head;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  xfer;
  logic                  slot_free;
  logic                  tx_nxt;
  logic [FLIT_WIDTH-1:0] data_nxt;
  logic                  done_nxt;

  assign clock_tx  = clock;
  assign accept    = (state == IDLE) && core.cmd_valid;
  assign xfer      = tx && credit_i;
  assign slot_free = !tx || credit_i;
  assign push      = core.pl_valid && core.pl_ready;

  ni_flit_fifo #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (core.pl_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (core.cmd_valid) state_nxt = HEADER;
      HEADER:  if (xfer) state_nxt = SIZE;
      SIZE:    if (xfer) state_nxt = (size_q == '0) ? IDLE : PAYLOAD;
      PAYLOAD: if (xfer && remaining == '0) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core.cmd_ready = (state == IDLE);
    core.pl_ready  = (state != IDLE) && !fifo_full && (accepted < size_q);
    busy           = (state != IDLE);
    tx_nxt         = tx;
    data_nxt       = data_out;
    done_nxt       = 1'b0;
    pop            = 1'b0;
    unique case (state)
      IDLE: begin
        if (core.cmd_valid) begin
          tx_nxt   = 1'b1;
          data_nxt = FLIT_WIDTH'(core.cmd_target);
        end
      end
      HEADER: begin
        if (xfer) data_nxt = size_q;
      end
      SIZE: begin
        if (xfer) begin
          if (size_q == '0) begin
            tx_nxt   = 1'b0;
            done_nxt = 1'b1;
          end else if (!fifo_empty) begin
            pop      = 1'b1;
            data_nxt = fifo_head;
          end else begin
            tx_nxt = 1'b0;
          end
        end
      end
      PAYLOAD: begin
        // remaining counts flits not yet loaded; zero while tx=1 means the slot holds the last one.
        if (slot_free) begin
          if (xfer && remaining == '0) begin
            tx_nxt   = 1'b0;
            done_nxt = 1'b1;
          end else if (remaining != '0 && !fifo_empty) begin
            pop      = 1'b1;
            tx_nxt   = 1'b1;
            data_nxt = fifo_head;
          end else begin
            tx_nxt = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx        <= 1'b0;
      data_out  <= '0;
      pkt_done  <= 1'b0;
      size_q    <= '0;
      remaining <= '0;
      accepted  <= '0;
    end else begin
      tx       <= tx_nxt;
      data_out <= data_nxt;
      pkt_done <= done_nxt;
      if (accept) begin
        size_q    <= core.cmd_size;
        remaining <= core.cmd_size;
        accepted  <= '0;
      end else begin
        if (pop)  remaining <= remaining - FLIT_WIDTH'(1);
        if (push) accepted  <= accepted + FLIT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ni_packet_tx.sv
// Scoreboard bench for ni_packet_tx: expected flit stream queued per packet, checked by a negedge monitor.
module tb_ni_packet_tx;
  import ni_packet_tx_pkg::*;

  logic   clock;
  logic   reset;
  logic   credit_i;
  logic   clock_tx;
  logic   tx;
  logic   busy;
  logic   pkt_done;
  regflit data_out;

  ni_packet_tx_if #(.FLIT_WIDTH(16)) core_if ();

  ni_packet_tx #(
    .FLIT_WIDTH (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .core     (core_if.slave),
    .clock_tx (clock_tx),
    .tx       (tx),
    .data_out (data_out),
    .credit_i (credit_i),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  int unsigned n_chk;
  int unsigned n_pass;
  regflit      exp_q[$];
  int unsigned len_q[$];
  int unsigned xfer_log[$];
  int unsigned cyc;
  int unsigned acc_cyc;
  int unsigned push_cnt;
  int unsigned stall_cnt;
  int unsigned cmode;
  bit          bubble_seen;
  bit          bg_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Credit source: 0 always on, 1 random, 2 always off, 3 stall the size flit for 4 cycles.
  initial begin
    credit_i = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (cmode)
        0: credit_i = 1'b1;
        1: credit_i = ($urandom_range(0, 99) < 70);
        2: credit_i = 1'b0;
        default: begin
          if (tx && data_out == 16'h0003 && stall_cnt < 4) begin
            credit_i = 1'b0;
            stall_cnt++;
          end else begin
            credit_i = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: a flit moves at the next posedge whenever tx && credit_i here.
  int unsigned cur_cnt;
  bit          expect_done;
  bit          prev_stall;
  regflit      prev_data;
  initial begin
    cur_cnt = 0; expect_done = 0; prev_stall = 0; prev_data = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        cur_cnt = 0; expect_done = 0; prev_stall = 0;
      end else begin
        chk("pkt_done", pkt_done, expect_done);
        if (expect_done) chk("busy_after_done", busy, 0);
        expect_done = 0;
        if (prev_stall) begin
          chk("hold_tx", tx, 1);
          chk("hold_data", data_out, prev_data);
        end
        prev_stall = tx && !credit_i;
        prev_data  = data_out;
        if (busy && !tx) bubble_seen = 1;
        if (core_if.pl_valid && core_if.pl_ready) push_cnt++;
        if (tx && credit_i) begin
          xfer_log.push_back(cyc);
          chk("flit_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("flit", data_out, exp_q.pop_front());
          if (len_q.size() != 0) begin
            cur_cnt++;
            if (cur_cnt == len_q[0]) begin
              void'(len_q.pop_front());
              cur_cnt = 0;
              expect_done = 1;
            end
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] tgt, input regflit n);
    int unsigned w;
    w = 0;
    core_if.cmd_valid  = 1'b1;
    core_if.cmd_target = tgt;
    core_if.cmd_size   = n;
    forever begin
      @(negedge clock);
      if (core_if.cmd_ready) break;
      w++;
      if (w > 500) begin
        chk("cmd_accept_timeout", core_if.cmd_ready, 1);
        break;
      end
    end
    acc_cyc = cyc;
    @(posedge clock);
    #1;
    core_if.cmd_valid = 1'b0;
  endtask

  task automatic drive_payload(input regflit d[$], input int unsigned gap,
                               input int unsigned pause_idx, input bit extra);
    int unsigned w;
    for (int unsigned i = 0; i < d.size(); i++) begin
      core_if.pl_valid = 1'b0;
      if (i == pause_idx) repeat (6) begin @(posedge clock); #1; end
      if (gap != 0) repeat ($urandom_range(0, gap)) begin @(posedge clock); #1; end
      core_if.pl_valid = 1'b1;
      core_if.pl_data  = d[i];
      w = 0;
      forever begin
        @(negedge clock);
        if (core_if.pl_ready) break;
        w++;
        if (w > 500) begin
          chk("pl_accept_timeout", core_if.pl_ready, 1);
          break;
        end
      end
      @(posedge clock);
      #1;
    end
    if (extra) begin
      core_if.pl_valid = 1'b1;
      core_if.pl_data  = 16'hDEAD;
      repeat (6) begin
        @(negedge clock);
        chk("excess_pl_refused", core_if.pl_ready, 0);
      end
      @(posedge clock);
      #1;
    end
    core_if.pl_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] tgt, input regflit d[$], input int unsigned gap,
                             input int unsigned pause_idx, input bit extra);
    exp_q.push_back({8'h00, tgt});
    exp_q.push_back(16'(d.size()));
    foreach (d[i]) exp_q.push_back(d[i]);
    len_q.push_back(d.size() + 2);
    fork
      send_cmd(tgt, 16'(d.size()));
      drive_payload(d, gap, pause_idx, extra);
    join
  endtask

  task automatic wait_drain();
    int unsigned w;
    w = 0;
    while ((exp_q.size() != 0 || len_q.size() != 0) && w < 3000) begin
      @(posedge clock);
      #1;
      w++;
    end
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_len", len_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  regflit pl[$];

  initial begin
    n_chk = 0; n_pass = 0; cmode = 0; push_cnt = 0; stall_cnt = 0;
    bubble_seen = 0; bg_done = 0;
    reset = 1'b0;
    core_if.cmd_valid = 1'b0; core_if.cmd_target = '0; core_if.cmd_size = '0;
    core_if.pl_valid = 1'b0; core_if.pl_data = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_tx", tx, 0);
    chk("reset_data", data_out, 0);
    chk("reset_pkt_done", pkt_done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pl_ready", core_if.pl_ready, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    chk("idle_cmd_ready", core_if.cmd_ready, 1);

    // Basic packet at full credit: five consecutive flits, header right after acceptance.
    pl = '{16'h00A1, 16'h00A2, 16'h00A3};
    xfer_log.delete();
    send_packet(8'h11, pl, 0, 99, 0);
    wait_drain();
    chk("t1_flit_count", xfer_log.size(), 5);
    if (xfer_log.size() >= 5) begin
      chk("t1_header_latency", xfer_log[0], acc_cyc + 1);
      for (int unsigned i = 1; i < 5; i++) chk("t1_back_to_back", xfer_log[i], xfer_log[i-1] + 1);
    end

    // Size flit held under 4 cycles of zero credit.
    stall_cnt = 0;
    cmode = 3;
    send_packet(8'h11, pl, 0, 99, 0);
    wait_drain();
    chk("t2_stall_cycles", stall_cnt, 4);
    cmode = 0;

    // Empty packet: header and size only, no payload ever accepted.
    pl.delete();
    send_packet(8'h22, pl, 0, 99, 1);
    wait_drain();

    // FIFO fills to depth under zero credit, then drains in order.
    cmode = 2;
    push_cnt = 0;
    bg_done = 0;
    pl = '{16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h0B05, 16'h0B06};
    fork
      begin
        send_packet(8'h44, pl, 0, 99, 0);
        bg_done = 1;
      end
    join_none
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("t4_pushes_before_full", push_cnt, 4);
    chk("t4_pl_ready_full", core_if.pl_ready, 0);
    chk("t4_header_held_tx", tx, 1);
    chk("t4_header_held_data", data_out, 16'h0044);
    @(posedge clock);
    #1;
    cmode = 0;
    for (int unsigned w = 0; w < 500 && !bg_done; w++) begin @(posedge clock); #1; end
    chk("t4_bg_done", bg_done, 1);
    wait_drain();

    // Payload stall mid-packet produces a bubble; the 7th flit is refused.
    bubble_seen = 0;
    pl = '{16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04, 16'h0C05, 16'h0C06};
    send_packet(8'h55, pl, 0, 3, 1);
    wait_drain();
    chk("t5_bubble", bubble_seen, 1);

    // Randomized traffic under random credit.
    cmode = 1;
    for (int unsigned p = 0; p < 24; p++) begin
      pl.delete();
      repeat ($urandom_range(0, 9)) pl.push_back(16'($urandom));
      send_packet(8'($urandom), pl, $urandom_range(0, 3), 99, ($urandom_range(0, 3) == 0));
    end
    wait_drain();
    cmode = 0;

    // Reset while in PAYLOAD abandons the packet.
    exp_q.push_back(16'h0066);
    exp_q.push_back(16'd8);
    exp_q.push_back(16'hB001);
    exp_q.push_back(16'hB002);
    len_q.push_back(10);
    send_cmd(8'h66, 16'd8);
    for (int unsigned i = 0; i < 2; i++) begin
      core_if.pl_valid = 1'b1;
      core_if.pl_data  = 16'hB001 + 16'(i);
      for (int unsigned w = 0; w < 50; w++) begin
        @(negedge clock);
        if (core_if.pl_ready) break;
      end
      @(posedge clock);
      #1;
    end
    core_if.pl_valid = 1'b0;
    repeat (6) begin @(posedge clock); #1; end
    chk("t6_busy_before_reset", busy, 1);
    chk("t6_sent_before_reset", exp_q.size(), 0);
    #2 reset = 1'b0;
    #1;
    chk("t6_tx_in_reset", tx, 0);
    chk("t6_busy_in_reset", busy, 0);
    chk("t6_data_in_reset", data_out, 0);
    chk("t6_pkt_done_in_reset", pkt_done, 0);
    exp_q.delete();
    len_q.delete();
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    pl = '{16'h0D01, 16'h0D02, 16'h0D03};
    send_packet(8'h77, pl, 1, 99, 1);
    wait_drain();

    repeat (4) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
